// File: rtl/operand_accumulator_if.sv
// Operand accumulator handshake bundle.
// Carries the operand input stream (valid/ready/data/last) and the
// group-result output stream (valid/ready/sum/count/sat).
// The producer/consumer side uses the master modport; the accumulator uses slave.
interface operand_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int ACC_W = WIDTH + 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_sat;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_count,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_count,
        output out_sat
    );
endinterface

// File: rtl/operand_accumulator.sv
// Sequential multi-operand summing stage.
// Accepts WIDTH-bit unsigned operands one per cycle and reduces each group of
// COUNT operands (or fewer, when closed early with in_last) to a single
// ACC_W-bit sum, presented on a registered valid/ready result port.
// Optional build macro ACC_SATURATE_EN: clamps the reported sum to 2^WIDTH-1
// and raises out_sat when the group total exceeds that value.
module operand_accumulator #(
    parameter int WIDTH = 16,
    parameter int COUNT = 4
) (
    input logic                   clk,
    input logic                   rst,
    operand_accumulator_if.slave  bus
);

    localparam int ACC_W = WIDTH + 8;
    localparam logic [7:0] COUNT_LIM = 8'(COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic [ACC_W-1:0] r_outSum;
    logic [7:0]       r_outCount;
    logic             r_outValid;
    logic             r_outSat;

    logic             w_inReady;
    logic             w_xfer;
    logic             w_close;
    logic             w_release;
    logic [ACC_W-1:0] w_dataExt;
    logic [ACC_W-1:0] w_accNext;
    logic [7:0]       w_cntNext;
    logic [ACC_W-1:0] w_resSum;
    logic             w_resSat;

    assign w_inReady = (r_state != HOLD);
    assign w_xfer    = bus.in_valid & w_inReady;
    assign w_release = (r_state == HOLD) & bus.out_ready;
    assign w_dataExt = {{(ACC_W-WIDTH){1'b0}}, bus.in_data};

    // The first operand of a group starts a fresh sum; later ones add to it.
    always_comb begin
        w_accNext = r_acc + w_dataExt;
        w_cntNext = r_cnt + 8'd1;
        if (r_state == IDLE) begin
            w_accNext = w_dataExt;
            w_cntNext = 8'd1;
        end
    end

    // A transfer closes the group when it is the COUNT-th operand or is
    // flagged last; both together still close it only once.
    assign w_close = w_xfer & (bus.in_last | (w_cntNext == COUNT_LIM));

`ifdef ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    // Clamp the final group total to the operand range and flag the clamp.
    always_comb begin
        w_resSum = w_accNext;
        w_resSat = 1'b0;
        if (w_accNext > SAT_MAX) begin
            w_resSum = SAT_MAX;
            w_resSat = 1'b1;
        end
    end
`else
    assign w_resSum = w_accNext;
    assign w_resSat = 1'b0;
`endif

    // Next-state decision: collect operands until the group closes, then
    // wait in HOLD until the consumer takes the result.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_xfer) begin
                    w_nextState = w_close ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, running sum and registered result; a reset anywhere discards
    // whatever partial or pending group exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_outSum   <= '0;
            r_outCount <= '0;
            r_outValid <= 1'b0;
            r_outSat   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_xfer) begin
                r_acc <= w_accNext;
                r_cnt <= w_cntNext;
            end
            if (w_close) begin
                r_outSum   <= w_resSum;
                r_outCount <= w_cntNext;
                r_outSat   <= w_resSat;
                r_outValid <= 1'b1;
            end
            if (w_release) begin
                r_outValid <= 1'b0;
                r_acc      <= '0;
                r_cnt      <= '0;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_sum   = r_outSum;
    assign bus.out_count = r_outCount;
    assign bus.out_sat   = r_outSat;

endmodule

// File: tb/tb_operand_accumulator.sv
// Self-checking bench for operand_accumulator.
// A behavioural model (running total, operand count, pending-result flag)
// predicts ready/valid and the reported result every cycle; directed cases
// from the test plan are additionally checked against fixed constants.
module tb_operand_accumulator;

    localparam int WIDTH = 16;
    localparam int COUNT = 4;
    localparam int ACC_W = WIDTH + 8;

    logic clk = 1'b0;
    logic rst;

    int numCompared   = 0;
    int numMismatched = 0;

    longint mAcc;
    int     mCnt;
    bit     mPend;
    longint mResSum;
    int     mResCnt;

    operand_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

    operand_accumulator #(
        .WIDTH(WIDTH),
        .COUNT(COUNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reported sum after optional clamping to the operand range.
    function automatic longint expSum(input longint total);
`ifdef ACC_SATURATE_EN
        return (total > 64'hFFFF) ? 64'hFFFF : total;
`else
        return total;
`endif
    endfunction

    function automatic bit expSat(input longint total);
`ifdef ACC_SATURATE_EN
        return total > 64'hFFFF;
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour for one clock edge, using the inputs as driven.
    task automatic modelClock();
        if (rst) begin
            mAcc  = 0;
            mCnt  = 0;
            mPend = 1'b0;
        end else if (mPend) begin
            if (bus.out_ready) mPend = 1'b0;
        end else if (bus.in_valid) begin
            mAcc += longint'(bus.in_data);
            mCnt++;
            if (mCnt == COUNT || bus.in_last) begin
                mPend   = 1'b1;
                mResSum = mAcc;
                mResCnt = mCnt;
                mAcc    = 0;
                mCnt    = 0;
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("inReady", 32'(bus.in_ready), 32'(!mPend));
        checkOutput("outValid", 32'(bus.out_valid), 32'(mPend));
        if (mPend) begin
            checkOutput("outSum", 32'(bus.out_sum), 32'(expSum(mResSum)));
            checkOutput("outCount", 32'(bus.out_count), 32'(mResCnt));
            checkOutput("outSat", 32'(bus.out_sat), 32'(expSat(mResSum)));
        end
    endtask

    // Drive one cycle of inputs, advance the model and compare just after the edge.
    task automatic applyStimulus(input bit valid, input logic [15:0] data, input bit last, input bit outReady);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.in_last   = last;
        bus.out_ready = outReady;
        @(posedge clk);
        modelClock();
        #1;
        compareModel();
    endtask

    task automatic expectResult(input string tag, input logic [31:0] sum, input logic [31:0] cnt, input logic [31:0] sat);
        checkOutput({tag, "Valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "Sum"}, 32'(bus.out_sum), sum);
        checkOutput({tag, "Count"}, 32'(bus.out_count), cnt);
        checkOutput({tag, "Sat"}, 32'(bus.out_sat), sat);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] fullOps [4];
        fullOps[0] = 16'hEC1C;
        fullOps[1] = 16'hFF46;
        fullOps[2] = 16'h1D7D;
        fullOps[3] = 16'hDD78;

        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        mAcc = 0; mCnt = 0; mPend = 1'b0; mResSum = 0; mResCnt = 0;

        // Reset state.
        pulseReset();
        checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
        checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstOutSum", 32'(bus.out_sum), 32'd0);
        checkOutput("rstOutCount", 32'(bus.out_count), 32'd0);
        checkOutput("rstOutSat", 32'(bus.out_sat), 32'd0);

        // Full group back-to-back; valid must rise right after the 4th transfer.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, fullOps[i], 1'b0, 1'b0);
`ifdef ACC_SATURATE_EN
        expectResult("full", 32'h00FFFF, 32'd4, 32'd1);
`else
        expectResult("full", 32'h02E657, 32'd4, 32'd0);
`endif
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

        // Short group closed by in_last; a following operand is not consumed while held.
        applyStimulus(1'b1, 16'h0160, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h369E, 1'b1, 1'b0);
        expectResult("short", 32'h0037FE, 32'd2, 32'd0);
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        expectResult("shortHeld", 32'h0037FE, 32'd2, 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

        // Backpressure with a waiting operand.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
            checkOutput("bpInReady", 32'(bus.in_ready), 32'd0);
            checkOutput("bpSum", 32'(bus.out_sum), 32'h000040);
        end
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        expectResult("bp", 32'h0048D0, 32'd4, 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

        // Reset mid-group discards the partial sum.
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b1);
        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        expectResult("rstMid", 32'h000004, 32'd4, 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

        // Idle bubbles between operands; in_last during bubbles has no effect.
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(1'b1, 16'(v), 1'b0, 1'b0);
            if (v < 4) begin
                int gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 16'hFFFF, 1'b1, 1'b0);
            end
        end
        expectResult("gaps", 32'h00000A, 32'd4, 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulseReset();
            end else begin
                applyStimulus($urandom_range(0, 9) < 7,
                              16'($urandom),
                              $urandom_range(0, 9) < 2,
                              $urandom_range(0, 9) < 6);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
